// File: rtl/sb_tx_multi_queue_serializer.sv
// Sideband transmit back end: per-class packet queues, RR/fixed-priority arbiter,
// LSB-first one-bit-per-UI serializer with inter-packet idle gap and clock pattern bursts.
module sb_tx_multi_queue_serializer #(
    parameter int NUM_CH = 2,
    parameter int PKT_W  = 64,
    parameter int DEPTH  = 4,
    parameter int GAP_UI = 32,
    parameter int RR_EN  = 1
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic [NUM_CH-1:0]                               i_wr_valid,
    input  logic [NUM_CH*PKT_W-1:0]                         i_wr_data,
    output logic [NUM_CH-1:0]                               o_wr_ready,
    input  logic                                            i_pattern_req,
    output logic                                            o_ser_data,
    output logic                                            o_ser_valid,
    output logic                                            o_pkt_done,
    output logic                                            o_busy,
    output logic [NUM_CH-1:0]                               o_fifo_empty,
    output logic [NUM_CH-1:0]                               o_overflow,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  o_grant_ch
);

    localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXV = (PKT_W > GAP_UI) ? PKT_W : GAP_UI;
    localparam int BW   = $clog2(MAXV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_PATTERN
    } state_t;

    state_t                  r_state;
    logic [BW-1:0]           r_cnt;
    logic [PKT_W-1:0]        r_shreg;
    logic [GW-1:0]           r_cur;
    logic [GW-1:0]           r_last;

    logic [NUM_CH-1:0]       w_empty;
    logic [NUM_CH-1:0]       w_full;
    logic [NUM_CH-1:0]       w_push;
    logic [NUM_CH-1:0]       w_pop;
    logic [NUM_CH*PKT_W-1:0] w_head_flat;
    logic [PKT_W-1:0]        w_head;
    logic                    w_any;
    logic [GW-1:0]           w_sel;
    logic                    w_dec;

    // Per-channel FIFOs; eligibility and readiness come only from registered counts.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_q
        logic [PKT_W-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wr_ptr;
        logic [AW-1:0]    r_rd_ptr;
        logic [CW-1:0]    r_count;
        logic             r_ovf;

        assign w_empty[c]   = (r_count == '0);
        assign w_full[c]    = (r_count == CW'(DEPTH));
        assign w_push[c]    = i_wr_valid[c] & ~w_full[c];
        assign w_pop[c]     = w_dec & ~i_pattern_req & w_any & (w_sel == GW'(c));
        assign w_head_flat[c*PKT_W +: PKT_W] = r_mem[r_rd_ptr];
        assign o_wr_ready[c]   = ~w_full[c];
        assign o_fifo_empty[c] = w_empty[c];
        assign o_overflow[c]   = r_ovf;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push[c]) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop[c])  r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                if (i_wr_valid[c] && w_full[c]) r_ovf <= 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (w_push[c]) r_mem[r_wr_ptr] <= i_wr_data[c*PKT_W +: PKT_W];
        end
    end

    // Arbiter: rotating search from the channel after the last grant, or plain lowest-index.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_sel = '0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_EN != 0) idx = (int'(r_last) + 1 + k) % NUM_CH;
            else            idx = k;
            if (!w_any && !w_empty[idx[GW-1:0]]) begin
                w_any = 1'b1;
                w_sel = GW'(idx);
            end
        end
    end

    always_comb begin
        w_head = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel == GW'(c)) w_head = w_head_flat[c*PKT_W +: PKT_W];
        end
    end

    assign w_dec = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_cnt == BW'(GAP_UI-1)));

    // Outputs are registered from the current state, so they trail the state by one UI.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur       <= '0;
            r_last      <= GW'(NUM_CH-1);
            o_ser_data  <= 1'b0;
            o_ser_valid <= 1'b0;
            o_pkt_done  <= 1'b0;
            o_busy      <= 1'b0;
            o_grant_ch  <= '0;
        end else begin
            o_busy      <= (r_state != S_IDLE);
            o_ser_data  <= 1'b0;
            o_ser_valid <= 1'b0;
            o_pkt_done  <= 1'b0;
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (!w_dec) begin
                        r_cnt <= r_cnt + BW'(1);
                    end else begin
                        r_cnt <= '0;
                        if (i_pattern_req) begin
                            r_state <= S_PATTERN;
                        end else if (w_any) begin
                            r_state <= S_SHIFT;
                            r_shreg <= w_head;
                            r_cur   <= w_sel;
                            r_last  <= w_sel;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SHIFT: begin
                    o_ser_valid <= 1'b1;
                    o_ser_data  <= r_shreg[0];
                    o_grant_ch  <= r_cur;
                    r_shreg     <= {1'b0, r_shreg[PKT_W-1:1]};
                    if (r_cnt == BW'(PKT_W-1)) begin
                        o_pkt_done <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + BW'(1);
                    end
                end
                S_PATTERN: begin
                    o_ser_valid <= 1'b1;
                    o_ser_data  <= ~r_cnt[0];
                    if (r_cnt == BW'(PKT_W-1)) begin
                        o_pkt_done <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= i_pattern_req ? S_PATTERN : S_GAP;
                    end else begin
                        r_cnt <= r_cnt + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_tx_multi_queue_serializer.sv
// Bench for sb_tx_multi_queue_serializer: round-robin and fixed-priority instances
// share stimulus and are both checked every cycle against a stream-level model.
module tb_sb_tx_multi_queue_serializer;

    localparam int NUM_CH = 2;
    localparam int PKT_W  = 64;
    localparam int DEPTH  = 4;
    localparam int GAP_UI = 32;
    localparam int GW     = 1;
    localparam logic [PKT_W-1:0] PAT_WORD = 64'h5555_5555_5555_5555;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       wr_valid = '0;
    logic [NUM_CH*PKT_W-1:0] wr_data = '0;
    logic                    pat = 1'b0;

    logic [NUM_CH-1:0] ready0, empty0, ovf0, ready1, empty1, ovf1;
    logic              sdata0, svalid0, done0, busy0, sdata1, svalid1, done1, busy1;
    logic [GW-1:0]     grant0, grant1;

    always #5 clk = ~clk;

    sb_tx_multi_queue_serializer #(.NUM_CH(NUM_CH), .PKT_W(PKT_W), .DEPTH(DEPTH),
                                   .GAP_UI(GAP_UI), .RR_EN(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .o_wr_ready(ready0), .i_pattern_req(pat), .o_ser_data(sdata0),
        .o_ser_valid(svalid0), .o_pkt_done(done0), .o_busy(busy0),
        .o_fifo_empty(empty0), .o_overflow(ovf0), .o_grant_ch(grant0));

    sb_tx_multi_queue_serializer #(.NUM_CH(NUM_CH), .PKT_W(PKT_W), .DEPTH(DEPTH),
                                   .GAP_UI(GAP_UI), .RR_EN(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .o_wr_ready(ready1), .i_pattern_req(pat), .o_ser_data(sdata1),
        .o_ser_valid(svalid1), .o_pkt_done(done1), .o_busy(busy1),
        .o_fifo_empty(empty1), .o_overflow(ovf1), .o_grant_ch(grant1));

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: each instance owns an expected output stream
    typedef struct packed {
        logic          v;
        logic          d;
        logic          done;
        logic          pkt;
        logic [GW-1:0] ch;
        logic [1:0]    kind;   // 0 plain UI, 1 last gap UI (decision), 2 last pattern UI
    } rec_t;

    logic [PKT_W-1:0] mq [2*NUM_CH][$];
    rec_t             sched [2][$];
    int               last_g [2];
    logic [1:0]        e_v, e_d, e_done, e_busy;
    logic [GW-1:0]     e_grant [2];
    logic [NUM_CH-1:0] e_rdy [2], e_emp [2], e_ovf [2];

    function automatic rec_t mk(input logic v, input logic d, input logic dn,
                                input logic pk, input logic [GW-1:0] ch, input logic [1:0] kd);
        rec_t r;
        r.v = v; r.d = d; r.done = dn; r.pkt = pk; r.ch = ch; r.kind = kd;
        return r;
    endfunction

    task automatic push_gap(input int i);
        for (int j = 0; j < GAP_UI; j++)
            sched[i].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, (j == GAP_UI-1) ? 2'd1 : 2'd0));
    endtask

    task automatic push_burst(input int i);
        for (int j = 0; j < PKT_W; j++)
            sched[i].push_back(mk(1'b1, (j % 2) == 0, j == PKT_W-1, 1'b0, '0,
                                  (j == PKT_W-1) ? 2'd2 : 2'd0));
    endtask

    task automatic decide(input int i);
        int ch;
        logic [PKT_W-1:0] w;
        if (pat) begin
            push_burst(i);
            return;
        end
        ch = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (i == 0) ? (last_g[i] + 1 + k) % NUM_CH : k;
            if (ch < 0 && mq[i*NUM_CH + c].size() > 0) ch = c;
        end
        if (ch < 0) return;
        w = mq[i*NUM_CH + ch].pop_front();
        last_g[i] = ch;
        for (int j = 0; j < PKT_W; j++)
            sched[i].push_back(mk(1'b1, w[j], j == PKT_W-1, 1'b1, GW'(ch), 2'd0));
        push_gap(i);
    endtask

    task automatic model_step(input int i);
        int   pre [NUM_CH];
        rec_t r;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) mq[i*NUM_CH + c].delete();
            sched[i].delete();
            last_g[i] = NUM_CH - 1;
            e_v[i] = 0; e_d[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_grant[i] = '0;
            e_rdy[i] = '1; e_emp[i] = '1; e_ovf[i] = '0;
            return;
        end
        for (int c = 0; c < NUM_CH; c++) pre[c] = mq[i*NUM_CH + c].size();
        if (sched[i].size() == 0) begin
            e_v[i] = 0; e_d[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            decide(i);
        end else begin
            r = sched[i].pop_front();
            e_v[i] = r.v; e_d[i] = r.d; e_done[i] = r.done; e_busy[i] = 1'b1;
            if (r.pkt) e_grant[i] = r.ch;
            if (r.kind == 2'd1) decide(i);
            else if (r.kind == 2'd2) begin
                if (pat) push_burst(i);
                else     push_gap(i);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_valid[c]) begin
                if (pre[c] < DEPTH) mq[i*NUM_CH + c].push_back(wr_data[c*PKT_W +: PKT_W]);
                else                e_ovf[i][c] = 1'b1;
            end
            e_rdy[i][c] = (mq[i*NUM_CH + c].size() < DEPTH);
            e_emp[i][c] = (mq[i*NUM_CH + c].size() == 0);
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [31:0] actv(input int i);
        if (i == 0) return {21'd0, svalid0, sdata0, done0, busy0, grant0, ready0, empty0, ovf0};
        return {21'd0, svalid1, sdata1, done1, busy1, grant1, ready1, empty1, ovf1};
    endfunction

    function automatic logic [31:0] expv(input int i);
        return {21'd0, e_v[i], e_d[i], e_done[i], e_busy[i], e_grant[i], e_rdy[i], e_emp[i], e_ovf[i]};
    endfunction

    // Every-cycle scoreboard plus capture of each finished word and its grant.
    logic [PKT_W-1:0] sh0, sh1;
    logic [PKT_W:0]   got0 [$];
    logic [PKT_W:0]   got1 [$];

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("stream_rr", actv(0), expv(0));
            check("stream_fp", actv(1), expv(1));
        end
        if (svalid0) sh0 = {sdata0, sh0[PKT_W-1:1]};
        if (done0)   got0.push_back({grant0, sh0});
        if (svalid1) sh1 = {sdata1, sh1[PKT_W-1:1]};
        if (done1)   got1.push_back({grant1, sh1});
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = '0; pat = 1'b0;
        tick(); tick();
        rst = 1'b0;
        got0.delete(); got1.delete();
    endtask

    task automatic wr(input int ch, input logic [PKT_W-1:0] d);
        wr_valid = '0;
        wr_valid[ch] = 1'b1;
        wr_data[ch*PKT_W +: PKT_W] = d;
        tick();
        wr_valid = '0;
    endtask

    function automatic int count_pkts();
        int n = 0;
        foreach (got0[k]) if (got0[k][PKT_W-1:0] != PAT_WORD) n++;
        return n;
    endfunction

    typedef struct {
        int   off;
        logic v;
        logic d;
        logic done;
        logic busy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int ti;
        int budget;
        logic [PKT_W-1:0] pk [$];
        logic [GW-1:0] ord_rr [6];
        logic [GW-1:0] ord_fp [6];

        tbl[0]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{4,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{5,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{7,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{18, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{34, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{64, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{65, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{66, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{97, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{98, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{99, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk_en = 1'b1;
        check("rst_ready", {30'd0, ready0}, 32'h3);
        check("rst_empty", {30'd0, empty0}, 32'h3);
        check("rst_outs", {27'd0, sdata0, svalid0, done0, busy0, grant0}, 32'h0);

        // Single packet on channel 0, plus a write to channel 1 in the last gap UI
        wr_valid = 2'b01; wr_data[63:0] = 64'hA5A5_0000_FFFF_1234;
        tick();
        wr_valid = '0;
        ti = 0;
        for (int k = 1; k <= 99; k++) begin
            if (k == 97) begin
                wr_valid = 2'b10; wr_data[127:64] = 64'h0000_0000_0000_0001;
            end else begin
                wr_valid = '0;
            end
            tick();
            if (ti < 13 && tbl[ti].off == k) begin
                check($sformatf("single_off%0d", k), {28'd0, svalid0, sdata0, done0, busy0},
                      {28'd0, tbl[ti].v, tbl[ti].d, tbl[ti].done, tbl[ti].busy});
                ti++;
            end
        end
        check("single_word", {31'd0, got0.size() >= 1 && got0[0][63:0] == 64'hA5A5_0000_FFFF_1234}, 32'd1);
        for (int k = 0; k < 120; k++) tick();

        // Grant order: three packets queued on both channels at once
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr_valid = 2'b11;
            wr_data = {64'h2000_0000_0000_0000 | 64'(k), 64'h1000_0000_0000_0000 | 64'(k)};
            tick();
        end
        wr_valid = '0;
        ord_rr = '{0, 1, 0, 1, 0, 1};
        ord_fp = '{0, 0, 0, 1, 1, 1};
        budget = 900;
        while ((got0.size() < 6 || got1.size() < 6) && budget > 0) begin tick(); budget--; end
        check("order_wait", {31'd0, budget > 0}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("order_rr%0d", k), {31'd0, (k < got0.size()) ? got0[k][PKT_W] : 1'bx},
                  {31'd0, ord_rr[k]});
            check($sformatf("order_fp%0d", k), {31'd0, (k < got1.size()) ? got1[k][PKT_W] : 1'bx},
                  {31'd0, ord_fp[k]});
        end

        // Overflow: five writes to channel 1 while pattern bursts hold the serializer
        do_reset();
        pat = 1'b1;
        tick();
        pk.delete();
        for (int k = 0; k < 5; k++) pk.push_back(64'hC0DE_0000_0000_0000 + 64'(k * 7 + 3));
        for (int k = 0; k < 4; k++) wr(1, pk[k]);
        check("ovf_ready_rr", {31'd0, ready0[1]}, 32'd0);
        check("ovf_ready_fp", {31'd0, ready1[1]}, 32'd0);
        wr(1, pk[4]);
        check("ovf_flag", {30'd0, ovf0}, 32'h2);
        pat = 1'b0;
        budget = 800;
        while (count_pkts() < 4 && budget > 0) begin tick(); budget--; end
        for (int k = 0; k < 40; k++) tick();
        check("ovf_npkts", count_pkts(), 4);
        ti = 0;
        foreach (got0[k]) begin
            if (got0[k][PKT_W-1:0] != PAT_WORD) begin
                if (ti < 4) check($sformatf("ovf_word%0d", ti), got0[k][31:0], pk[ti][31:0]);
                ti++;
            end
        end

        // Reset at bit 20 of a packet
        wr_valid = 2'b11; wr_data = {64'h1111_2222_3333_4444, 64'h9999_8888_7777_6666};
        tick();
        wr_valid = '0;
        budget = 200;
        while (!svalid0 && budget > 0) begin tick(); budget--; end
        check("mid_start", {31'd0, svalid0}, 32'd1);
        for (int k = 0; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, svalid0}, 32'd0);
        check("mid_rst_empty", {30'd0, empty0}, 32'h3);
        check("mid_rst_ovf", {30'd0, ovf0}, 32'h0);
        got0.delete(); got1.delete();
        wr(0, 64'hFEED_FACE_0BAD_F00D);
        budget = 200;
        while (got0.size() < 1 && budget > 0) begin tick(); budget--; end
        check("mid_fresh", (got0.size() >= 1) ? got0[0][31:0] : 32'hxxxxxxxx, 32'h0BAD_F00D);

        // Pattern held 150 UI from IDLE with a packet pending
        for (int k = 0; k < 120; k++) tick();
        do_reset();
        pat = 1'b1;
        for (int k = 0; k < 150; k++) begin
            wr_valid = (k == 10) ? 2'b01 : 2'b00;
            wr_data[63:0] = 64'h0123_4567_89AB_CDEF;
            tick();
        end
        pat = 1'b0; wr_valid = '0;
        budget = 400;
        while (got0.size() < 4 && budget > 0) begin tick(); budget--; end
        check("pat_wait", {31'd0, budget > 0}, 32'd1);
        for (int k = 0; k < 3; k++)
            check($sformatf("pat_burst%0d", k), (k < got0.size()) ? got0[k][31:0] : 32'hxxxxxxxx,
                  PAT_WORD[31:0]);
        check("pat_then_pkt", (got0.size() >= 4) ? got0[3][31:0] : 32'hxxxxxxxx, 32'h89AB_CDEF);

        // Randomized traffic with occasional pattern requests and resets
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NUM_CH; c++) wr_valid[c] = ($urandom_range(47) == 0);
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(299) == 0) pat = ~pat;
            rst = ($urandom_range(1999) == 0);
            tick();
        end
        wr_valid = '0; pat = 1'b0; rst = 1'b0;
        for (int k = 0; k < 200; k++) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
